// File: rtl/fwd_hazard_unit_if.sv
// Stage-field bundle between the pipeline and the forwarding/hazard unit.
// master: pipeline side (drives DX/XM/MW fields and mult/div result, reads operands and control).
// slave : hazard unit side (the reverse).
interface fwd_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);
  // DX stage
  logic [RA_W-1:0]   dx_rs1;
  logic [RA_W-1:0]   dx_rs2;
  logic              dx_rs1_used;
  logic              dx_rs2_used;
  logic [RA_W-1:0]   dx_rd;
  logic              dx_wen;
  logic              dx_is_md;
  logic [DATA_W-1:0] dx_a;
  logic [DATA_W-1:0] dx_b;
  // XM stage
  logic [RA_W-1:0]   xm_rd;
  logic              xm_wen;
  logic              xm_is_load;
  logic [DATA_W-1:0] xm_o;
  // MW stage
  logic [RA_W-1:0]   mw_rd;
  logic              mw_wen;
  logic [DATA_W-1:0] mw_data;
  // mult/div unit result
  logic              md_ready;
  logic [DATA_W-1:0] md_result;
  // outputs of the hazard unit
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              stall;
  logic              md_start;
  logic              md_wb_valid;
  logic [RA_W-1:0]   md_wb_rd;
  logic [DATA_W-1:0] md_wb_data;
  logic              md_busy;
  logic              md_timeout;

  modport master (
    output dx_rs1, dx_rs2, dx_rs1_used, dx_rs2_used, dx_rd, dx_wen, dx_is_md, dx_a, dx_b,
    output xm_rd, xm_wen, xm_is_load, xm_o, mw_rd, mw_wen, mw_data, md_ready, md_result,
    input  alu_a, alu_b, fwd_sel_a, fwd_sel_b, stall, md_start,
    input  md_wb_valid, md_wb_rd, md_wb_data, md_busy, md_timeout
  );

  modport slave (
    input  dx_rs1, dx_rs2, dx_rs1_used, dx_rs2_used, dx_rd, dx_wen, dx_is_md, dx_a, dx_b,
    input  xm_rd, xm_wen, xm_is_load, xm_o, mw_rd, mw_wen, mw_data, md_ready, md_result,
    output alu_a, alu_b, fwd_sel_a, fwd_sel_b, stall, md_start,
    output md_wb_valid, md_wb_rd, md_wb_data, md_busy, md_timeout
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding (XM > MW > held MD result > regfile), load-use stall and a
// one-entry mult/div scoreboard with writeback arbitration against MW and a watchdog.
// Ports: clock, reset (sync, active-high), bus (slave side of fwd_hazard_unit_if).
// Forwarding is combinational (0 cycles); stall holds PC/FD/DX and bubbles XM.
module fwd_hazard_unit #(
  parameter int DATA_W        = 32,
  parameter int RA_W          = 5,
  parameter int MD_MAX_CYCLES = 64
) (
  input logic              clock,
  input logic              reset,
  fwd_hazard_unit_if.slave bus
);

  localparam int CNT_W = $clog2(MD_MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_MAX_CYCLES - 1);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_XM = 2'd1;
  localparam logic [1:0] SEL_MW = 2'd2;
  localparam logic [1:0] SEL_MD = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [RA_W-1:0]   md_dest_q;
  logic [DATA_W-1:0] md_res_q;
  logic [CNT_W-1:0]  cnt_q;

  // ---------------- forwarding ----------------
  logic rs1_ok, rs2_ok;
  logic xm_fwd_ok, md_fwd_ok;
  logic [1:0] sel_a, sel_b;

  assign rs1_ok    = bus.dx_rs1_used && (bus.dx_rs1 != '0);
  assign rs2_ok    = bus.dx_rs2_used && (bus.dx_rs2 != '0);
  // A load in XM has no data yet; it is covered by the load-use stall instead.
  assign xm_fwd_ok = bus.xm_wen && !bus.xm_is_load;
  assign md_fwd_ok = (state_q == DONE);

  function automatic logic [1:0] fwd_pick(
    input logic            ok,
    input logic [RA_W-1:0] rs,
    input logic            xm_ok,
    input logic [RA_W-1:0] xm_rd,
    input logic            mw_ok,
    input logic [RA_W-1:0] mw_rd,
    input logic            md_ok,
    input logic [RA_W-1:0] md_rd
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (ok) begin
      if (xm_ok && xm_rd == rs)      sel = SEL_XM;
      else if (mw_ok && mw_rd == rs) sel = SEL_MW;
      else if (md_ok && md_rd == rs) sel = SEL_MD;
    end
    return sel;
  endfunction

  assign sel_a = fwd_pick(rs1_ok, bus.dx_rs1, xm_fwd_ok, bus.xm_rd, bus.mw_wen, bus.mw_rd,
                          md_fwd_ok, md_dest_q);
  assign sel_b = fwd_pick(rs2_ok, bus.dx_rs2, xm_fwd_ok, bus.xm_rd, bus.mw_wen, bus.mw_rd,
                          md_fwd_ok, md_dest_q);

  logic [DATA_W-1:0] opnd_a, opnd_b;

  always_comb begin
    opnd_a = bus.dx_a;
    case (sel_a)
      SEL_XM:  opnd_a = bus.xm_o;
      SEL_MW:  opnd_a = bus.mw_data;
      SEL_MD:  opnd_a = md_res_q;
      default: opnd_a = bus.dx_a;
    endcase
  end

  always_comb begin
    opnd_b = bus.dx_b;
    case (sel_b)
      SEL_XM:  opnd_b = bus.xm_o;
      SEL_MW:  opnd_b = bus.mw_data;
      SEL_MD:  opnd_b = md_res_q;
      default: opnd_b = bus.dx_b;
    endcase
  end

  assign bus.alu_a     = opnd_a;
  assign bus.alu_b     = opnd_b;
  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;

  // ---------------- hazards ----------------
  logic load_hz, md_hz, md_raw, md_waw, stall_w, start_w;

  assign load_hz = bus.xm_wen && bus.xm_is_load && (bus.xm_rd != '0) &&
                   ((rs1_ok && bus.dx_rs1 == bus.xm_rd) || (rs2_ok && bus.dx_rs2 == bus.xm_rd));

  assign md_raw  = (rs1_ok && bus.dx_rs1 == md_dest_q) || (rs2_ok && bus.dx_rs2 == md_dest_q);
  assign md_waw  = bus.dx_wen && (bus.dx_rd == md_dest_q);
  // A zero destination never occupies the scoreboard.
  assign md_hz   = (state_q != IDLE) && (md_dest_q != '0) && (md_raw || md_waw || bus.dx_is_md);

  // DONE always stalls so the held result is never overtaken while it waits for the port.
  assign stall_w = load_hz || md_hz || (state_q == DONE);
  assign start_w = bus.dx_is_md && !stall_w;

  assign bus.stall    = stall_w;
  assign bus.md_start = start_w;

  // ---------------- scoreboard / writeback ----------------
  logic wb_w, done_exit, timeout_w;

  // MW owns the regfile write port; the held result waits for a free cycle.
  assign wb_w      = (state_q == DONE) && !bus.mw_wen && (md_dest_q != '0);
  assign done_exit = (state_q == DONE) && (!bus.mw_wen || md_dest_q == '0);
  // md_ready takes precedence over the watchdog in the same cycle.
  assign timeout_w = (state_q == BUSY) && !bus.md_ready && (cnt_q == CNT_LAST);

  assign bus.md_wb_valid = wb_w;
  assign bus.md_wb_rd    = md_dest_q;
  assign bus.md_wb_data  = md_res_q;
  assign bus.md_busy     = (state_q != IDLE);
  assign bus.md_timeout  = timeout_w;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      md_dest_q <= '0;
      md_res_q  <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_w) begin
            md_dest_q <= bus.dx_rd;
            cnt_q     <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.md_ready) begin
            md_res_q <= bus.md_result;
            state_q  <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (done_exit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
